pulse_tracer: RTL and testbench

//   Cleans an asynchronous, noisy 1-bit input and emits a 1-clock pulse per accepted rising edge.
//   - Input path: synchronizer, then a stability filter, then an edge detector.
//   - Sits at the boundary between raw external signals and clk-domain control logic.

---
 rtl/pulse_tracer_pkg.sv | 13 +
 rtl/pulse_tracer_sync.sv | 27 ++
 rtl/pulse_tracer.sv | 85 ++++++++
 tb/tb_pulse_tracer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_tracer_pkg.sv
// Shared constants and helpers for the pulse_tracer input conditioner.
package pulse_tracer_pkg;

    // Default synchronizer depth and stability window.
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 1;

    // Width of a counter that must hold values 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_tracer_sync.sv
// N-flop synchronizer for an asynchronous 1-bit input, synchronous active-low reset.
module pulse_tracer_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;

    // Shift the raw input through the flop chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/pulse_tracer.sv
// pulse_tracer: synchronizes a noisy asynchronous input, accepts a new level only
// after STABLE_CYCLES consecutive synced samples, and emits a 1-cycle strobe per
// accepted rising edge.
// Optional macro PULSE_TRACER_BOTH_EDGES_EN: strobe on accepted falling edges too.
module pulse_tracer
    import pulse_tracer_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_in,
    output logic pulse_out
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Reject illegal configurations at elaboration.
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("pulse_tracer: SYNC_STAGES must be >= 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("pulse_tracer: STABLE_CYCLES must be >= 1");
    end

    logic             s;
    logic             filt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             pulse_d;

    pulse_tracer_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (noisy_in),
        .q     (s)
    );

    // A new level is accepted on the last cycle of an unbroken run of differing samples.
    always_comb begin
        accept = (s != filt) && (cnt == CNT_LAST);
    end

`ifdef PULSE_TRACER_BOTH_EDGES_EN
    // Strobe on every accepted transition, either polarity.
    always_comb begin
        pulse_d = accept;
    end
`else
    // Strobe only when the accepted level is high (rising edge).
    always_comb begin
        pulse_d = accept && s;
    end
`endif

    // Stability filter: count differing samples, restart on any return to filt,
    // saturating at the acceptance point so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (s == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= s;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered output strobe; high for the single cycle in which filt takes the new level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_out <= 1'b0;
        end else begin
            pulse_out <= pulse_d;
        end
    end

endmodule

// File: tb/tb_pulse_tracer.sv
// Directed testbench for pulse_tracer: a per-cycle vector table on the default
// instance plus hand-written sequences for glitches, long stability windows and
// reset corner cases on a STABLE_CYCLES=4 instance.
module tb_pulse_tracer;

`ifdef PULSE_TRACER_BOTH_EDGES_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, noisy_a, pulse_a;
    logic rst_n_b, noisy_b, pulse_b;

    pulse_tracer dut_a (
        .clk       (clk),
        .rst_n     (rst_n_a),
        .noisy_in  (noisy_a),
        .pulse_out (pulse_a)
    );

    pulse_tracer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .noisy_in  (noisy_b),
        .pulse_out (pulse_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one posedge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table (default instance) ----------------
    // Inputs are applied before posedge i; outputs are sampled 1 ns after it.
    // exp_fall marks a cycle that pulses only in both-edges builds.
    typedef struct {
        logic rst_n;
        logic noisy;
        logic exp_pulse;
        logic exp_fall;
        logic exp_filt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // reset held with input high
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        // release: pulse two edges later
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        // falling edge
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        // single-sample high at posedge 10
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        int pulses;
        rst_n_a = 1'b0;
        noisy_a = 1'b1;
        rst_n_b = 1'b0;
        noisy_b = 1'b0;
        #1;

        // Table: reset with input high, latency, falling edge, single-sample pulse.
        for (int i = 0; i < 16; i++) begin
            rst_n_a = vecs[i].rst_n;
            noisy_a = vecs[i].noisy;
            tick();
            check($sformatf("vec%0d_pulse", i), pulse_a,
                  vecs[i].exp_pulse | (vecs[i].exp_fall & BE));
            check($sformatf("vec%0d_filt", i), dut_a.filt, vecs[i].exp_filt);
        end

        // Glitch of 2 ns between posedges: never sampled.
        for (int i = 0; i < 3; i++) begin
            #3 noisy_a = 1'b1;
            #2 noisy_a = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("glitch_pulse", pulse_a, 1'b0);
            check("glitch_filt", dut_a.filt, 1'b0);
        end

        // Held high 20 cycles: exactly one pulse, then falling edge.
        pulses = 0;
        noisy_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulse_a) pulses++;
        end
        check("held_high_one_pulse", (pulses == 1), 1'b1);
        pulses = 0;
        noisy_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pulse_a) pulses++;
        end
        check("falling_pulse_count", (pulses == (BE ? 1 : 0)), 1'b1);

        // Reset in the pulse_out cycle kills the strobe at the next posedge.
        noisy_a = 1'b1;
        tick(); tick();
        tick();
        check("pre_reset_pulse", pulse_a, 1'b1);
        rst_n_a = 1'b0;
        tick();
        check("reset_kills_pulse", pulse_a, 1'b0);
        check("reset_clears_filt", dut_a.filt, 1'b0);
        rst_n_a = 1'b1;
        tick(); tick();
        check("post_reset_no_early", pulse_a, 1'b0);
        tick();
        check("post_reset_repulse", pulse_a, 1'b1);
        noisy_a = 1'b0;

        // STABLE_CYCLES=4: three samples high is rejected.
        rst_n_b = 1'b1;
        noisy_b = 1'b0;
        tick(); tick(); tick();
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            noisy_b = (i < 3);
            tick();
            if (pulse_b) pulses++;
        end
        check("stable4_three_rejected", (pulses == 0), 1'b1);

        // Four samples high: pulse exactly at posedge k+5, falling pulse at k+9 if enabled.
        for (int i = 0; i < 15; i++) begin
            noisy_b = (i < 4);
            tick();
            check($sformatf("stable4_four_c%0d", i), pulse_b,
                  (i == 5) || (BE && i == 9));
        end

        // Reset mid-count restarts the count from zero after release.
        noisy_b = 1'b1;
        tick(); tick(); tick();   // s high for two edges, count in progress
        rst_n_b = 1'b0;
        tick();
        check("midcount_reset_pulse", pulse_b, 1'b0);
        rst_n_b = 1'b1;           // release edge R is the next posedge
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("midcount_restart_c%0d", i), pulse_b, (i == 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
